// File: rtl/bus_fabric_if.sv
// Shared-bus signal bundle between two masters, the fabric and two slaves.
// The fabric takes the slave modport; masters and slaves drive through the master modport.
interface bus_fabric_if;
    logic        M0_req;
    logic        M0_wr;
    logic [7:0]  M0_address;
    logic [31:0] M0_dout;
    logic        M1_req;
    logic        M1_wr;
    logic [7:0]  M1_address;
    logic [31:0] M1_dout;
    logic        M0_grant;
    logic        M1_grant;
    logic [31:0] M_din;
    logic        S0_sel;
    logic        S1_sel;
    logic        S_wr;
    logic [7:0]  S_address;
    logic [31:0] S_din;
    logic [31:0] S0_dout;
    logic [31:0] S1_dout;
    logic        bus_err;

    modport slave (
        input  M0_req, M0_wr, M0_address, M0_dout,
        input  M1_req, M1_wr, M1_address, M1_dout,
        input  S0_dout, S1_dout,
        output M0_grant, M1_grant, M_din,
        output S0_sel, S1_sel, S_wr, S_address, S_din,
        output bus_err
    );

    modport master (
        output M0_req, M0_wr, M0_address, M0_dout,
        output M1_req, M1_wr, M1_address, M1_dout,
        output S0_dout, S1_dout,
        input  M0_grant, M1_grant, M_din,
        input  S0_sel, S1_sel, S_wr, S_address, S_din,
        input  bus_err
    );
endinterface

// File: rtl/bus_fabric.sv
// Two-master shared-bus fabric: arbiter, address decode, write steering and
// one-cycle-latency registered read return with a sticky unmapped-access flag.
//
// state | meaning
// GNT0  | M0 owns the bus (reset state; M0 wins simultaneous requests)
// GNT1  | M1 owns the bus until it drops its request (no preemption)
module bus_fabric #(
    parameter logic [7:0] S0_BASE = 8'h00,
    parameter logic [7:0] S0_MASK = 8'hE0,
    parameter logic [7:0] S1_BASE = 8'h70,
    parameter logic [7:0] S1_MASK = 8'hF0
) (
    input  logic        clk,
    input  logic        reset,
    bus_fabric_if.slave bus
);

    localparam logic [0:0] GNT0 = 1'b0;
    localparam logic [0:0] GNT1 = 1'b1;

    localparam logic [1:0] RSEL_NONE = 2'd0;
    localparam logic [1:0] RSEL_S0   = 2'd1;
    localparam logic [1:0] RSEL_S1   = 2'd2;

    logic [0:0]  state;
    logic [0:0]  state_next;
    logic        granted_req;
    logic        granted_wr;
    logic [7:0]  granted_address;
    logic [31:0] granted_dout;
    logic        hit0;
    logic        hit1;
    logic        s0_sel;
    logic        s1_sel;
    logic [1:0]  rsel;
    logic [1:0]  rsel_next;
    logic [31:0] m_din;
    logic        bus_err;

    always_comb begin
        state_next = state;
        case (state)
            GNT0:    if (!bus.M0_req && bus.M1_req) state_next = GNT1;
            GNT1:    if (!bus.M1_req)               state_next = GNT0;
            default: state_next = GNT0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= GNT0;
        else       state <= state_next;
    end

    // Request is masked during reset so no slave sees a select while the bus is being reset.
    always_comb begin
        granted_req     = 1'b0;
        granted_wr      = bus.M0_wr;
        granted_address = bus.M0_address;
        granted_dout    = bus.M0_dout;
        if (state == GNT1) begin
            granted_wr      = bus.M1_wr;
            granted_address = bus.M1_address;
            granted_dout    = bus.M1_dout;
            granted_req     = bus.M1_req & ~reset;
        end else begin
            granted_req     = bus.M0_req & ~reset;
        end
    end

    assign hit0   = (granted_address & S0_MASK) == S0_BASE;
    assign hit1   = (granted_address & S1_MASK) == S1_BASE;
    assign s0_sel = granted_req & hit0;
    assign s1_sel = granted_req & hit1 & ~hit0;

    always_comb begin
        rsel_next = RSEL_NONE;
        if (granted_req && !granted_wr) begin
            if (s0_sel)      rsel_next = RSEL_S0;
            else if (s1_sel) rsel_next = RSEL_S1;
        end
    end

    // Read return pipeline keeps running across grant changes; only reset discards it.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsel    <= RSEL_NONE;
            m_din   <= 32'h0;
            bus_err <= 1'b0;
        end else begin
            rsel <= rsel_next;
            case (rsel)
                RSEL_S0: m_din <= bus.S0_dout;
                RSEL_S1: m_din <= bus.S1_dout;
                default: m_din <= 32'h0;
            endcase
            if (granted_req && !hit0 && !hit1) bus_err <= 1'b1;
        end
    end

    assign bus.M0_grant  = (state == GNT0);
    assign bus.M1_grant  = (state == GNT1);
    assign bus.S0_sel    = s0_sel;
    assign bus.S1_sel    = s1_sel;
    assign bus.S_wr      = granted_wr & granted_req;
    assign bus.S_address = granted_address;
    assign bus.S_din     = granted_dout;
    assign bus.M_din     = m_din;
    assign bus.bus_err   = bus_err;

endmodule

// File: tb/tb_bus_fabric.sv
// Directed bench for bus_fabric: decode vector table plus hand-written
// arbitration, read-pipeline, unmapped-access and reset sequences.
module tb_bus_fabric;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    bus_fabric_if bus ();

    bus_fabric #(
        .S0_BASE(8'h00), .S0_MASK(8'hE0), .S1_BASE(8'h70), .S1_MASK(8'hF0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic        exp_s0;
        logic        exp_s1;
        logic        exp_swr;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_masters();
        bus.M0_req = 1'b0; bus.M0_wr = 1'b0; bus.M0_address = 8'h00; bus.M0_dout = 32'h0;
        bus.M1_req = 1'b0; bus.M1_wr = 1'b0; bus.M1_address = 8'h00; bus.M1_dout = 32'h0;
    endtask

    task automatic do_reset();
        idle_masters();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 8'h05, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 8'h72, 32'h12345678, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 8'h1F, 32'h0,        1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 8'h00, 32'h0,        1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 8'h7F, 32'h0,        1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 8'h05, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 8'h20, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 8'h6F, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 8'h80, 32'h0,        1'b0, 1'b0, 1'b0};

        bus.S0_dout = 32'h0;
        bus.S1_dout = 32'h0;
        idle_masters();
        reset = 1'b1;

        // Reset with M1 requesting: M0 still owns the bus, no selects
        bus.M1_req = 1'b1;
        bus.M1_address = 8'h70;
        tick();
        tick();
        chk("rst_m0_grant", {31'h0, bus.M0_grant}, 32'h1);
        chk("rst_m1_grant", {31'h0, bus.M1_grant}, 32'h0);
        chk("rst_m_din",    bus.M_din, 32'h0);
        chk("rst_bus_err",  {31'h0, bus.bus_err}, 32'h0);
        chk("rst_s0_sel",   {31'h0, bus.S0_sel}, 32'h0);
        chk("rst_s1_sel",   {31'h0, bus.S1_sel}, 32'h0);
        idle_masters();
        reset = 1'b0;
        tick();

        // Handover to M1, no preemption, return to M0
        bus.M1_req = 1'b1;
        #1 chk("ho_m0_still", {31'h0, bus.M0_grant}, 32'h1);
        tick();
        chk("ho_m1_grant", {31'h0, bus.M1_grant}, 32'h1);
        bus.M0_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ho_m1_hold", {31'h0, bus.M1_grant}, 32'h1);
        end
        bus.M1_req = 1'b0;
        #1 chk("ho_m1_drop_same", {31'h0, bus.M1_grant}, 32'h1);
        tick();
        chk("ho_m0_back", {31'h0, bus.M0_grant}, 32'h1);

        // Simultaneous requests in GNT0 stay with M0
        bus.M1_req = 1'b1;
        tick();
        chk("simul_m0", {31'h0, bus.M0_grant}, 32'h1);
        // M1 takes the bus, then drops while M0 raises
        bus.M0_req = 1'b0;
        tick();
        chk("m1_take", {31'h0, bus.M1_grant}, 32'h1);
        bus.M1_req = 1'b0;
        bus.M0_req = 1'b1;
        tick();
        chk("swap_m0", {31'h0, bus.M0_grant}, 32'h1);
        do_reset();

        // Decode table driven by M0 in GNT0
        for (int i = 0; i < 9; i++) begin
            bus.M0_req = vecs[i].req;
            bus.M0_wr = vecs[i].wr;
            bus.M0_address = vecs[i].addr;
            bus.M0_dout = vecs[i].data;
            #1;
            chk($sformatf("vec%0d_s0", i),   {31'h0, bus.S0_sel}, {31'h0, vecs[i].exp_s0});
            chk($sformatf("vec%0d_s1", i),   {31'h0, bus.S1_sel}, {31'h0, vecs[i].exp_s1});
            chk($sformatf("vec%0d_swr", i),  {31'h0, bus.S_wr},   {31'h0, vecs[i].exp_swr});
            chk($sformatf("vec%0d_addr", i), {24'h0, bus.S_address}, {24'h0, vecs[i].addr});
            chk($sformatf("vec%0d_din", i),  bus.S_din, vecs[i].data);
            tick();
        end
        do_reset();

        // Read pipeline from M1: S1 then S0 on consecutive cycles
        bus.M1_req = 1'b1;
        tick();
        chk("rp_m1_grant", {31'h0, bus.M1_grant}, 32'h1);
        bus.M1_wr = 1'b0;
        bus.M1_address = 8'h70;
        #1 chk("rp_s1_sel", {31'h0, bus.S1_sel}, 32'h1);
        tick();
        bus.M1_address = 8'h03;
        bus.S1_dout = 32'h11;
        #1 chk("rp_s0_sel", {31'h0, bus.S0_sel}, 32'h1);
        tick();
        bus.M1_req = 1'b0;
        bus.S1_dout = 32'h0;
        bus.S0_dout = 32'h22;
        #1 chk("rp_first", bus.M_din, 32'h11);
        tick();
        bus.S0_dout = 32'h0;
        chk("rp_second", bus.M_din, 32'h22);
        chk("rp_no_err", {31'h0, bus.bus_err}, 32'h0);
        do_reset();

        // Mapped read followed by unmapped read from M0
        bus.M0_req = 1'b1;
        bus.M0_wr = 1'b0;
        bus.M0_address = 8'h03;
        tick();
        bus.M0_address = 8'h40;
        bus.S0_dout = 32'h5A5A5A5A;
        bus.S1_dout = 32'hBBBBBBBB;
        #1;
        chk("um_s0_sel", {31'h0, bus.S0_sel}, 32'h0);
        chk("um_s1_sel", {31'h0, bus.S1_sel}, 32'h0);
        chk("um_err_before", {31'h0, bus.bus_err}, 32'h0);
        tick();
        bus.M0_req = 1'b0;
        chk("um_prev_data", bus.M_din, 32'h5A5A5A5A);
        chk("um_err_set", {31'h0, bus.bus_err}, 32'h1);
        tick();
        chk("um_m_din_zero", bus.M_din, 32'h0);
        for (int i = 0; i < 3; i++) tick();
        chk("um_err_sticky", {31'h0, bus.bus_err}, 32'h1);
        bus.S0_dout = 32'h0;
        bus.S1_dout = 32'h0;
        do_reset();
        chk("um_err_cleared", {31'h0, bus.bus_err}, 32'h0);

        // Reset the cycle after an S0 read: in-flight data is discarded
        bus.M0_req = 1'b1;
        bus.M0_wr = 1'b0;
        bus.M0_address = 8'h03;
        tick();
        reset = 1'b1;
        bus.S0_dout = 32'h12345678;
        #1 chk("mr_sel_in_reset", {31'h0, bus.S0_sel}, 32'h0);
        tick();
        chk("mr_m_din", bus.M_din, 32'h0);
        chk("mr_m0_grant", {31'h0, bus.M0_grant}, 32'h1);
        reset = 1'b0;
        idle_masters();
        tick();
        chk("mr_m_din_after", bus.M_din, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
